// File: rtl/regarb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regarb_pkg;

    localparam int             REG_AW       = 5;
    localparam int             REG_DW       = 32;
    localparam logic [4:0]     REG_ZERO     = 5'd0;
    localparam int             MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_LU   = 2'd2
    } grant_e;

endpackage

// File: rtl/regarb_scoreboard.sv
// Busy scoreboard for outstanding long-latency results: issue gating,
// decode busy queries and the sticky ordering-violation flag.
module regarb_scoreboard
    import regarb_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue,
    input  logic [REG_AW-1:0] i_issue_rd,
    input  logic              i_lu_xfer,
    input  logic [REG_AW-1:0] i_lu_rd,
    input  logic              i_wb_xfer,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [REG_AW-1:0] i_q_rs,
    input  logic [REG_AW-1:0] i_q_rt,
    output logic              o_issue_ready,
    output logic              o_q_rs_busy,
    output logic              o_q_rt_busy,
    output logic              o_sb_err
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic            r_sb_err;
    logic            w_viol;

    assign o_issue_ready = rst_n && ((i_issue_rd == REG_ZERO) || !r_busy[i_issue_rd]);

    // r0 is never reserved, so its busy bit stays permanently clear
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_r0
                assign w_set[gi] = 1'b0;
            end else begin : g_rn
                assign w_set[gi] = i_issue && o_issue_ready && (i_issue_rd == REG_AW'(gi));
            end
            assign w_clr[gi] = i_lu_xfer && (i_lu_rd == REG_AW'(gi));
        end
    endgenerate

    // Transfers here are real (non-r0) writes only; r0 results carry no ordering
    assign w_viol = (i_lu_xfer && !r_busy[i_lu_rd]) || (i_wb_xfer && r_busy[i_wb_rd]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_busy   <= (r_busy & ~w_clr) | w_set;
            r_sb_err <= r_sb_err | w_viol;
        end
    end

    assign o_q_rs_busy = (i_q_rs != REG_ZERO) && r_busy[i_q_rs];
    assign o_q_rt_busy = (i_q_rt != REG_ZERO) && r_busy[i_q_rt];
    assign o_sb_err    = r_sb_err;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between WB and the long-latency unit.
// Optional decode bypass outputs are built when REGARB_FWD_EN is defined.
module regfile_wb_arbiter
    import regarb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int NREG     = 32,
    parameter int DW       = REG_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wb_valid,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [DW-1:0]     i_wb_wd,
    output logic              o_wb_ready,
    input  logic              i_lu_issue,
    input  logic [REG_AW-1:0] i_lu_issue_rd,
    output logic              o_lu_issue_ready,
    input  logic              i_lu_valid,
    input  logic [REG_AW-1:0] i_lu_rd,
    input  logic [DW-1:0]     i_lu_wd,
    output logic              o_lu_ready,
    input  logic [REG_AW-1:0] i_q_rs,
    input  logic [REG_AW-1:0] i_q_rt,
    output logic              o_q_rs_busy,
    output logic              o_q_rt_busy,
    output logic              o_rf_we,
    output logic [REG_AW-1:0] o_rf_rd,
    output logic [DW-1:0]     o_rf_wd,
    output logic              o_sb_err
`ifdef REGARB_FWD_EN
    ,
    output logic              o_q_rs_fwd,
    output logic              o_q_rt_fwd,
    output logic [DW-1:0]     o_fwd_wd
`endif
);

    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

    logic       w_wb_real;
    logic       w_lu_real;
    grant_e     w_gnt;
    logic [3:0] r_starve_cnt;

    assign w_wb_real = i_wb_valid && (i_wb_rd != REG_ZERO);
    assign w_lu_real = i_lu_valid && (i_lu_rd != REG_ZERO);

    always_comb begin
        w_gnt = GNT_NONE;
        if (w_wb_real && w_lu_real) begin
            w_gnt = (r_starve_cnt == C_MAX_WAIT) ? GNT_LU : GNT_WB;
        end else if (w_wb_real) begin
            w_gnt = GNT_WB;
        end else if (w_lu_real) begin
            w_gnt = GNT_LU;
        end
        if (!rst_n) begin
            w_gnt = GNT_NONE;
        end
    end

    // r0 requests are acknowledged immediately without touching the port
    assign o_wb_ready = rst_n && i_wb_valid && ((i_wb_rd == REG_ZERO) || (w_gnt == GNT_WB));
    assign o_lu_ready = rst_n && i_lu_valid && ((i_lu_rd == REG_ZERO) || (w_gnt == GNT_LU));

    always_comb begin
        o_rf_we = 1'b0;
        o_rf_rd = REG_ZERO;
        o_rf_wd = '0;
        case (w_gnt)
            GNT_WB: begin
                o_rf_we = 1'b1;
                o_rf_rd = i_wb_rd;
                o_rf_wd = i_wb_wd;
            end
            GNT_LU: begin
                o_rf_we = 1'b1;
                o_rf_rd = i_lu_rd;
                o_rf_wd = i_lu_wd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!w_lu_real || (w_gnt == GNT_LU)) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != C_MAX_WAIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    regarb_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_issue       (i_lu_issue),
        .i_issue_rd    (i_lu_issue_rd),
        .i_lu_xfer     (w_gnt == GNT_LU),
        .i_lu_rd       (i_lu_rd),
        .i_wb_xfer     (w_gnt == GNT_WB),
        .i_wb_rd       (i_wb_rd),
        .i_q_rs        (i_q_rs),
        .i_q_rt        (i_q_rt),
        .o_issue_ready (o_lu_issue_ready),
        .o_q_rs_busy   (o_q_rs_busy),
        .o_q_rt_busy   (o_q_rt_busy),
        .o_sb_err      (o_sb_err)
    );

`ifdef REGARB_FWD_EN
    assign o_q_rs_fwd = o_rf_we && (o_rf_rd == i_q_rs) && (i_q_rs != REG_ZERO);
    assign o_q_rt_fwd = o_rf_we && (o_rf_rd == i_q_rt) && (i_q_rt != REG_ZERO);
    assign o_fwd_wd   = o_rf_wd;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table for single-cycle
// arbitration plus sequences for reset, starvation, scoreboard and errors.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid, lu_issue, lu_valid;
    logic [4:0]  wb_rd, lu_issue_rd, lu_rd, q_rs, q_rt;
    logic [31:0] wb_wd, lu_wd;
    logic        wb_ready, lu_issue_ready, lu_ready, q_rs_busy, q_rt_busy;
    logic        rf_we, sb_err;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .MAX_WAIT (4),
        .NREG     (32),
        .DW       (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_wb_valid       (wb_valid),
        .i_wb_rd          (wb_rd),
        .i_wb_wd          (wb_wd),
        .o_wb_ready       (wb_ready),
        .i_lu_issue       (lu_issue),
        .i_lu_issue_rd    (lu_issue_rd),
        .o_lu_issue_ready (lu_issue_ready),
        .i_lu_valid       (lu_valid),
        .i_lu_rd          (lu_rd),
        .i_lu_wd          (lu_wd),
        .o_lu_ready       (lu_ready),
        .i_q_rs           (q_rs),
        .i_q_rt           (q_rt),
        .o_q_rs_busy      (q_rs_busy),
        .o_q_rt_busy      (q_rt_busy),
        .o_rf_we          (rf_we),
        .o_rf_rd          (rf_rd),
        .o_rf_wd          (rf_wd),
        .o_sb_err         (sb_err)
    );

    typedef struct {
        logic        wb_v;
        logic [4:0]  wb_rd;
        logic [31:0] wb_wd;
        logic        lu_v;
        logic [4:0]  lu_rd;
        logic [31:0] lu_wd;
        logic        e_wbr;
        logic        e_lur;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        wb_valid = 1'b0; wb_rd = 5'd0; wb_wd = 32'h0;
        lu_issue = 1'b0; lu_issue_rd = 5'd0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_wd = 32'h0;
        q_rs = 5'd0; q_rt = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[1] = '{1'b1, 5'd3, 32'hDEADBEEF,  1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd4, 32'h00001234,  1'b0, 1'b1, 1'b1, 5'd4, 32'h00001234};
        vecs[3] = '{1'b1, 5'd5, 32'hAAAA5555,  1'b1, 5'd6, 32'hBBBB6666,  1'b1, 1'b0, 1'b1, 5'd5, 32'hAAAA5555};
        vecs[4] = '{1'b1, 5'd0, 32'h0000CAFE,  1'b1, 5'd7, 32'h77777777,  1'b1, 1'b1, 1'b1, 5'd7, 32'h77777777};
        vecs[5] = '{1'b1, 5'd8, 32'h88888888,  1'b1, 5'd0, 32'h12345678,  1'b1, 1'b1, 1'b1, 5'd8, 32'h88888888};
        vecs[6] = '{1'b1, 5'd0, 32'h11111111,  1'b1, 5'd0, 32'h22222222,  1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 32'h33333333,  1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
        vecs[8] = '{1'b0, 5'd9, 32'h99999999,  1'b0, 5'd10, 32'h10101010, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-traffic with r5 reserved
        @(negedge clk);
        lu_issue = 1'b1; lu_issue_rd = 5'd5;
        #1 chk("issue_r5_ready", lu_issue_ready, 1);
        @(negedge clk);
        lu_issue = 1'b0; q_rs = 5'd5;
        #1 chk("r5_busy_before_reset", q_rs_busy, 1);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_wd = 32'hA5A5A5A5;
        lu_valid = 1'b1; lu_rd = 5'd5; lu_wd = 32'h5A5A5A5A;
        lu_issue = 1'b1; lu_issue_rd = 5'd6;
        #1 chk("pre_reset_wb_ready", wb_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_lu_ready", lu_ready, 0);
        chk("rst_issue_ready", lu_issue_ready, 0);
        $display("reset mid-traffic: rf_we=%0d wb_ready=%0d lu_ready=%0d", rf_we, wb_ready, lu_ready);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        q_rs = 5'd5;
        #1;
        chk("post_reset_r5_busy", q_rs_busy, 0);
        chk("post_reset_sb_err", sb_err, 0);

        // Single-cycle arbitration table, each vector followed by an idle cycle
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wb_valid = vecs[i].wb_v; wb_rd = vecs[i].wb_rd; wb_wd = vecs[i].wb_wd;
            lu_valid = vecs[i].lu_v; lu_rd = vecs[i].lu_rd; lu_wd = vecs[i].lu_wd;
            #1;
            chk($sformatf("vec%0d_wb_ready", i), wb_ready, vecs[i].e_wbr);
            chk($sformatf("vec%0d_lu_ready", i), lu_ready, vecs[i].e_lur);
            chk($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].e_we);
            chk($sformatf("vec%0d_rf_rd", i), rf_rd, vecs[i].e_rd);
            chk($sformatf("vec%0d_rf_wd", i), rf_wd, vecs[i].e_wd);
            $display("vec %0d: wb_ready=%0d lu_ready=%0d rf_we=%0d rf_rd=%0d rf_wd=0x%08h",
                     i, wb_ready, lu_ready, rf_we, rf_rd, rf_wd);
            @(negedge clk);
            clear_inputs();
        end

        // Starvation: WB hammers r1, LU holds a result for reserved r9
        do_reset();
        @(negedge clk);
        lu_issue = 1'b1; lu_issue_rd = 5'd9;
        #1 chk("issue_r9_ready", lu_issue_ready, 1);
        @(negedge clk);
        lu_issue = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_wd = 32'h11110000;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_wd = 32'h99990000;
        q_rs = 5'd9;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("starve%0d_lu_ready", k), lu_ready, (k == 4) ? 1 : 0);
            chk($sformatf("starve%0d_wb_ready", k), wb_ready, (k == 4) ? 0 : 1);
            chk($sformatf("starve%0d_rf_rd", k), rf_rd, (k == 4) ? 9 : 1);
            chk($sformatf("starve%0d_r9_busy", k), q_rs_busy, 1);
            $display("starve cycle %0d: wb_ready=%0d lu_ready=%0d rf_rd=%0d", k, wb_ready, lu_ready, rf_rd);
            @(negedge clk);
        end
        lu_valid = 1'b0;
        #1;
        chk("starve_r9_cleared", q_rs_busy, 0);
        chk("starve_wb_resumes", wb_ready, 1);
        chk("starve_sb_err", sb_err, 0);

        // Issue to a busy register blocks until the LU r12 transfer
        do_reset();
        @(negedge clk);
        lu_issue = 1'b1; lu_issue_rd = 5'd12;
        #1 chk("issue_r12_first", lu_issue_ready, 1);
        @(negedge clk);
        q_rs = 5'd12;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("issue_r12_blocked%0d", k), lu_issue_ready, 0);
            chk($sformatf("q_r12_busy%0d", k), q_rs_busy, 1);
            $display("issue r12 again, cycle %0d: lu_issue_ready=%0d busy=%0d", k, lu_issue_ready, q_rs_busy);
            @(negedge clk);
        end
        lu_valid = 1'b1; lu_rd = 5'd12; lu_wd = 32'hC0DE0012;
        #1;
        chk("r12_result_ready", lu_ready, 1);
        chk("r12_result_wd", rf_wd, 32'hC0DE0012);
        chk("issue_r12_still_blocked", lu_issue_ready, 0);
        @(negedge clk);
        lu_valid = 1'b0;
        #1;
        chk("issue_r12_unblocked", lu_issue_ready, 1);
        chk("q_r12_free", q_rs_busy, 0);
        chk("q_rt_r0_busy", q_rt_busy, 0);
        chk("issue_seq_sb_err", sb_err, 0);
        lu_issue = 1'b0;

        // Violation: LU result to unreserved r20
        do_reset();
        @(negedge clk);
        lu_valid = 1'b1; lu_rd = 5'd20; lu_wd = 32'h20202020;
        #1;
        chk("viol_lu_ready", lu_ready, 1);
        chk("viol_rf_we", rf_we, 1);
        chk("viol_rf_rd", rf_rd, 20);
        chk("viol_sb_err_before", sb_err, 0);
        @(negedge clk);
        lu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("viol_sb_err_held%0d", k), sb_err, 1);
            $display("lu violation, cycle %0d: sb_err=%0d", k, sb_err);
            @(negedge clk);
        end

        // Violation: WB write to a reserved register
        do_reset();
        #1 chk("sb_err_cleared_by_reset", sb_err, 0);
        @(negedge clk);
        lu_issue = 1'b1; lu_issue_rd = 5'd11;
        @(negedge clk);
        lu_issue = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd11; wb_wd = 32'h0B0B0B0B;
        #1 chk("wb_to_busy_ready", wb_ready, 1);
        @(negedge clk);
        wb_valid = 1'b0;
        #1 chk("wb_viol_sb_err", sb_err, 1);
        $display("wb violation: sb_err=%0d", sb_err);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
